block_dot_accumulator: RTL

- Computes the signed dot product of one row-segment and one column-segment of length n, then hands the block's partial sum to the downstream signed adder stage.
- Sits directly upstream of that adder, which combines partial sums from successive blocks into the final C element.
- Element pairs arrive one at a time over a strobe/ack handshake. One result leaves per n accepted pairs over a strobe/ack handshake.

---
 rtl/block_dot_accumulator_if.sv | 13 +
 rtl/block_dot_accumulator.sv | 81 ++++++++
 2 files changed

// File: rtl/block_dot_accumulator_if.sv
// block_dot_accumulator_if: element-pair input and result output strobe/ack bus
interface block_dot_accumulator_if #(parameter int w = 8);
  logic [w-1:0] input_a, input_b, output_z;
  logic input_stb, input_ack, output_z_ovf, output_z_stb, output_z_ack;
  modport master(
    output input_a, input_b, input_stb, output_z_ack,
    input  input_ack, output_z, output_z_ovf, output_z_stb
  );
  modport slave(
    input  input_a, input_b, input_stb, output_z_ack,
    output input_ack, output_z, output_z_ovf, output_z_stb
  );
endinterface

// File: rtl/block_dot_accumulator.sv
// block_dot_accumulator: signed dot product over n pairs, one registered partial sum per n pairs
module block_dot_accumulator #(
  parameter int w = 8,
  parameter int n = 4
) (
  input logic clk,
  input logic rst,
  block_dot_accumulator_if.slave bus
);
  localparam int AW = (n > 2) ? 2 * w + $clog2(n) : 2 * w + 1;
  localparam int CW = (n > 1) ? $clog2(n) : 1;
  typedef enum logic [1:0] {ACCEPT, MULT, ADD, OUT} state_t;
  state_t state_q, state_d;
  logic signed [w-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic signed [2*w-1:0] prod_q, prod_d;
  logic signed [AW-1:0] acc_q, acc_d, acc_sum;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d, last;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    prod_d = prod_q;
    acc_d = acc_q;
    count_d = count_q;
    z_d = z_q;
    ovf_d = ovf_q;
    acc_sum = acc_q + {{(AW-2*w){prod_q[2*w-1]}}, prod_q};
    last = count_q == CW'(n - 1);
    unique case (state_q)
      ACCEPT: if (bus.input_stb) begin
        a_d = bus.input_a;
        b_d = bus.input_b;
        state_d = MULT;
      end
      MULT: begin
        prod_d = {{w{a_q[w-1]}}, a_q} * {{w{b_q[w-1]}}, b_q};
        state_d = ADD;
      end
      ADD: begin
        acc_d = acc_sum;
        count_d = count_q + CW'(1);
        // result fits in w bits only if all bits above the w-bit sign agree with it
        z_d = last ? acc_sum[w-1:0] : z_q;
        ovf_d = last ? ~(&acc_sum[AW-1:w-1] | ~|acc_sum[AW-1:w-1]) : ovf_q;
        state_d = last ? OUT : ACCEPT;
      end
      OUT: if (bus.output_z_ack) begin
        acc_d = '0;
        count_d = '0;
        state_d = ACCEPT;
      end
      default: state_d = ACCEPT;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACCEPT;
      a_q <= '0;
      b_q <= '0;
      prod_q <= '0;
      acc_q <= '0;
      count_q <= '0;
      z_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      prod_q <= prod_d;
      acc_q <= acc_d;
      count_q <= count_d;
      z_q <= z_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.input_ack = rst && state_q == ACCEPT;
  assign bus.output_z = z_q;
  assign bus.output_z_ovf = ovf_q;
  assign bus.output_z_stb = state_q == OUT;
endmodule
